// File: rtl/mesh_wormhole_ni_tx_pkg.sv
// Shared flit definitions for the wormhole mesh: flit ID codes, flit width,
// HEAD field offsets (also used by the node routing logic) and NI FSM states.
package mesh_wormhole_ni_tx_pkg;

   // Flit type codes; 2'b00 is reserved as invalid and never emitted.
   localparam logic [1:0] FlitInvalid = 2'b00;
   localparam logic [1:0] FlitHead    = 2'b01;
   localparam logic [1:0] FlitBody    = 2'b10;
   localparam logic [1:0] FlitTail    = 2'b11;

   // Full flit width, laid out as {id, data}.
   function automatic int unsigned calc_flit_w(input int unsigned id_w,
                                               input int unsigned data_w);
      return id_w + data_w;
   endfunction

   // Data-field range of a flit: data occupies [data_w-1:0] below the ID.
   function automatic int unsigned calc_data_range(input int unsigned data_w);
      return data_w - 1;
   endfunction

   // HEAD layout: row in the MSBs, column just below, hop count in the LSBs.
   function automatic int unsigned head_row_lsb(input int unsigned data_w,
                                                input int unsigned row_w);
      return data_w - row_w;
   endfunction

   function automatic int unsigned head_col_lsb(input int unsigned data_w,
                                                input int unsigned row_w,
                                                input int unsigned col_w);
      return data_w - row_w - col_w;
   endfunction

   typedef enum logic [0:0] {
      StIdle,
      StPayload
   } ni_tx_state_e;

endpackage

// File: rtl/mesh_wormhole_ni_tx.sv
// Network-interface transmitter: turns a request plus payload stream into a
// HEAD/BODY.../TAIL worm on one node input channel, one flit per cycle.
module mesh_wormhole_ni_tx
   import mesh_wormhole_ni_tx_pkg::*;
#(
   parameter int unsigned FLIT_DATA_W = 8,
   parameter int unsigned FLIT_ID_W   = 2,
   parameter int unsigned HOP_CNT_W   = 4,
   parameter int unsigned ROW_ADDR_W  = 2,
   parameter int unsigned COL_ADDR_W  = 2,
   parameter int unsigned LEN_W       = 4,
   localparam int unsigned FLIT_W     = calc_flit_w(FLIT_ID_W, FLIT_DATA_W)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   pkt_vld_i,
   output logic                   pkt_rdy_o,
   input  logic [ROW_ADDR_W-1:0]  pkt_dst_row_i,
   input  logic [COL_ADDR_W-1:0]  pkt_dst_col_i,
   input  logic [LEN_W-1:0]       pkt_len_i,
   input  logic [FLIT_DATA_W-1:0] data_i,
   input  logic                   data_vld_i,
   output logic                   data_rdy_o,
   output logic [FLIT_W-1:0]      out_chan_data_o,
   output logic                   out_chan_vld_o,
   input  logic                   out_chan_rdy_i,
   output logic                   pkt_sent_o,
   output logic                   len_err_o
);

   localparam int unsigned DataMsb    = calc_data_range(FLIT_DATA_W);
   localparam int unsigned HeadRowLsb = head_row_lsb(FLIT_DATA_W, ROW_ADDR_W);
   localparam int unsigned HeadColLsb = head_col_lsb(FLIT_DATA_W, ROW_ADDR_W, COL_ADDR_W);

   if (FLIT_DATA_W < ROW_ADDR_W + COL_ADDR_W + HOP_CNT_W) begin : g_head_too_narrow
      $error("FLIT_DATA_W cannot hold the HEAD row, column and hop fields");
   end

   ni_tx_state_e             state_q;
   logic [LEN_W-1:0]         cnt_q;
   logic                     out_vld_q;
   logic [FLIT_W-1:0]        out_flit_q;

   logic                     load_ok;
   logic                     pkt_hs;
   logic                     data_hs;
   logic                     len_zero;
   logic                     last_word;
   logic [FLIT_DATA_W-1:0]   head_data;
   logic [FLIT_ID_W-1:0]     out_id;

   // Output register can take a new flit when empty or draining this cycle.
   assign load_ok   = !out_vld_q || out_chan_rdy_i;
   assign pkt_hs    = pkt_vld_i && pkt_rdy_o;
   assign data_hs   = data_vld_i && data_rdy_o;
   assign len_zero  = (pkt_len_i == '0);
   assign last_word = (cnt_q == LEN_W'(1));
   assign out_id    = out_flit_q[FLIT_W-1 -: FLIT_ID_W];

   // HEAD payload: destination in the MSBs, hop count and padding zeroed.
   always_comb begin
      head_data = '0;
      head_data[HeadRowLsb +: ROW_ADDR_W] = pkt_dst_row_i;
      head_data[HeadColLsb +: COL_ADDR_W] = pkt_dst_col_i;
   end

   // Ready decode: one of the two request sides, only while out of reset.
   always_comb begin
      pkt_rdy_o  = 1'b0;
      data_rdy_o = 1'b0;
      if (rst_ni) begin
         pkt_rdy_o  = (state_q == StIdle) && load_ok;
         data_rdy_o = (state_q == StPayload) && load_ok;
      end
   end

   // Status pulses, both tied to the handshake cycle that causes them.
   always_comb begin
      len_err_o  = pkt_hs && len_zero;
      pkt_sent_o = out_vld_q && out_chan_rdy_i && (out_id == FLIT_ID_W'(FlitTail));
   end

   // Packetizer FSM with payload counter and the single output flit register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         out_vld_q  <= 1'b0;
         out_flit_q <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pkt_hs && !len_zero) begin
                  cnt_q      <= pkt_len_i;
                  out_vld_q  <= 1'b1;
                  out_flit_q <= {FLIT_ID_W'(FlitHead), head_data};
                  state_q    <= StPayload;
               end else if (load_ok) begin
                  out_vld_q <= 1'b0;
               end
            end
            StPayload: begin
               if (data_hs) begin
                  cnt_q      <= cnt_q - LEN_W'(1);
                  out_vld_q  <= 1'b1;
                  out_flit_q <= {last_word ? FLIT_ID_W'(FlitTail) : FLIT_ID_W'(FlitBody),
                                 data_i[DataMsb:0]};
                  if (last_word) begin
                     state_q <= StIdle;
                  end
               end else if (load_ok) begin
                  out_vld_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign out_chan_vld_o  = out_vld_q;
   assign out_chan_data_o = out_flit_q;

endmodule

// File: tb/tb_mesh_wormhole_ni_tx.sv
// Directed bench for mesh_wormhole_ni_tx plus a randomized scoreboard run.
module tb_mesh_wormhole_ni_tx;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       pkt_vld;
   logic       pkt_rdy;
   logic [1:0] row;
   logic [1:0] col;
   logic [3:0] len;
   logic [7:0] data;
   logic       data_vld;
   logic       data_rdy;
   logic [9:0] out_data;
   logic       out_vld;
   logic       out_rdy;
   logic       pkt_sent;
   logic       len_err;

   typedef struct {
      logic [9:0] flit;
      logic       sent;
      int         cyc;
   } mon_t;

   typedef struct {
      logic [1:0] row;
      logic [1:0] col;
      logic [3:0] len;
   } req_t;

   mon_t       mon_q[$];
   req_t       rq_q[$];
   logic [7:0] wd_q[$];
   logic [9:0] rnd_exp[$];
   int         cyc_cnt    = 0;
   int         stray_sent = 0;
   int         n_cmp      = 0;
   int         n_bad      = 0;
   logic       feed_done;

   mesh_wormhole_ni_tx dut (
      .clk_i           (clk),
      .rst_ni          (rst_ni),
      .pkt_vld_i       (pkt_vld),
      .pkt_rdy_o       (pkt_rdy),
      .pkt_dst_row_i   (row),
      .pkt_dst_col_i   (col),
      .pkt_len_i       (len),
      .data_i          (data),
      .data_vld_i      (data_vld),
      .data_rdy_o      (data_rdy),
      .out_chan_data_o (out_data),
      .out_chan_vld_o  (out_vld),
      .out_chan_rdy_i  (out_rdy),
      .pkt_sent_o      (pkt_sent),
      .len_err_o       (len_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Log every output handshake; inputs change only on the falling edge.
   always @(negedge clk) begin
      #2;
      if (rst_ni && out_vld && out_rdy) begin
         mon_q.push_back('{flit: out_data, sent: pkt_sent, cyc: cyc_cnt});
      end else if (pkt_sent) begin
         stray_sent++;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, got hang, want completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   // Call at a falling edge; returns at the falling edge after the handshake.
   task automatic send_req(input logic [1:0] r, input logic [1:0] c, input logic [3:0] l);
      int g = 0;
      pkt_vld = 1'b1;
      row     = r;
      col     = c;
      len     = l;
      #1;
      while (!pkt_rdy && g < 100) begin
         @(negedge clk);
         #1;
         g++;
      end
      if (g >= 100) check("req_timeout", g, 0);
      @(negedge clk);
      pkt_vld = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      int g = 0;
      data_vld = 1'b1;
      data     = w;
      #1;
      while (!data_rdy && g < 100) begin
         @(negedge clk);
         #1;
         g++;
      end
      if (g >= 100) check("word_timeout", g, 0);
      @(negedge clk);
      data_vld = 1'b0;
   endtask

   task automatic chk_seq(input string tag, input int base, input logic [9:0] e[$]);
      check({tag, "_count"}, mon_q.size() - base, e.size());
      for (int i = 0; i < e.size() && base + i < mon_q.size(); i++) begin
         check({tag, "_flit"}, mon_q[base+i].flit, e[i]);
         check({tag, "_sent"}, mon_q[base+i].sent, e[i][9:8] == 2'b11);
      end
   endtask

   task automatic rnd_req_drv();
      foreach (rq_q[i]) begin
         int g = 0;
         @(negedge clk);
         pkt_vld = 1'b0;
         while ($urandom_range(3) == 0) @(negedge clk);
         pkt_vld = 1'b1;
         row     = rq_q[i].row;
         col     = rq_q[i].col;
         len     = rq_q[i].len;
         #1;
         while (!pkt_rdy && g < 2000) begin
            @(negedge clk);
            #1;
            g++;
         end
         if (g >= 2000) begin
            check("rnd_req_timeout", g, 0);
            break;
         end
      end
      @(negedge clk);
      pkt_vld = 1'b0;
   endtask

   task automatic rnd_data_drv();
      foreach (wd_q[i]) begin
         int g = 0;
         @(negedge clk);
         data_vld = 1'b0;
         while ($urandom_range(3) == 0) @(negedge clk);
         data_vld = 1'b1;
         data     = wd_q[i];
         #1;
         while (!data_rdy && g < 2000) begin
            @(negedge clk);
            #1;
            g++;
         end
         if (g >= 2000) begin
            check("rnd_data_timeout", g, 0);
            break;
         end
      end
      @(negedge clk);
      data_vld = 1'b0;
   endtask

   initial begin
      int         base;
      int         c0;
      logic [9:0] e[$];

      // Reset: a pending request must not be acknowledged.
      rst_ni   = 1'b0;
      pkt_vld  = 1'b1;
      row      = 2'd1;
      col      = 2'd1;
      len      = 4'd1;
      data     = 8'h00;
      data_vld = 1'b1;
      out_rdy  = 1'b1;
      #2;
      check("rst_vld", out_vld, 0);
      check("rst_data", out_data, 0);
      check("rst_pkt_rdy", pkt_rdy, 0);
      check("rst_data_rdy", data_rdy, 0);
      check("rst_sent", pkt_sent, 0);
      check("rst_len_err", len_err, 0);
      @(negedge clk);
      pkt_vld  = 1'b0;
      data_vld = 1'b0;
      @(negedge clk);
      rst_ni = 1'b1;

      // Single packet, constant ready.
      @(negedge clk);
      base = mon_q.size();
      send_req(2'd2, 2'd1, 4'd3);
      #1;
      check("t1_head_vld", out_vld, 1);
      check("t1_head", out_data, {2'b01, 8'h90});
      @(negedge clk);
      send_word(8'hA1);
      send_word(8'hA2);
      send_word(8'hA3);
      repeat (2) @(negedge clk);
      e = '{{2'b01, 8'h90}, {2'b10, 8'hA1}, {2'b10, 8'hA2}, {2'b11, 8'hA3}};
      chk_seq("t1", base, e);

      // Backpressure right after HEAD.
      @(negedge clk);
      base = mon_q.size();
      send_req(2'd2, 2'd1, 4'd3);
      out_rdy  = 1'b0;
      data_vld = 1'b1;
      data     = 8'hA1;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t2_hold_vld", out_vld, 1);
         check("t2_hold_data", out_data, {2'b01, 8'h90});
         check("t2_data_rdy", data_rdy, 0);
         @(negedge clk);
      end
      out_rdy  = 1'b1;
      data_vld = 1'b0;
      send_word(8'hA1);
      send_word(8'hA2);
      send_word(8'hA3);
      repeat (2) @(negedge clk);
      chk_seq("t2", base, e);

      // len=1 then len=2 back to back: five flits in five consecutive cycles.
      @(negedge clk);
      base    = mon_q.size();
      pkt_vld = 1'b1;
      row     = 2'd1;
      col     = 2'd3;
      len     = 4'd1;
      #1 check("t3_rdy_a", pkt_rdy, 1);
      @(negedge clk);
      pkt_vld  = 1'b0;
      data_vld = 1'b1;
      data     = 8'h55;
      #1 check("t3_drdy_a", data_rdy, 1);
      @(negedge clk);
      data_vld = 1'b0;
      pkt_vld  = 1'b1;
      row      = 2'd3;
      col      = 2'd0;
      len      = 4'd2;
      #1 check("t3_rdy_b", pkt_rdy, 1);
      @(negedge clk);
      pkt_vld  = 1'b0;
      data_vld = 1'b1;
      data     = 8'h66;
      #1 check("t3_drdy_b", data_rdy, 1);
      @(negedge clk);
      data = 8'h77;
      #1 check("t3_drdy_c", data_rdy, 1);
      @(negedge clk);
      data_vld = 1'b0;
      repeat (2) @(negedge clk);
      e = '{{2'b01, 8'h70}, {2'b11, 8'h55}, {2'b01, 8'hC0}, {2'b10, 8'h66}, {2'b11, 8'h77}};
      chk_seq("t3", base, e);
      for (int i = 1; i < 5 && base + i < mon_q.size(); i++) begin
         check("t3_gap", mon_q[base+i].cyc - mon_q[base+i-1].cyc, 1);
      end

      // len=0: error pulse, nothing emitted, then a normal len=1 packet.
      @(negedge clk);
      base    = mon_q.size();
      pkt_vld = 1'b1;
      row     = 2'd1;
      col     = 2'd1;
      len     = 4'd0;
      #1;
      check("t4_len_err", len_err, 1);
      check("t4_rdy", pkt_rdy, 1);
      @(negedge clk);
      pkt_vld = 1'b0;
      #1;
      check("t4_len_err_off", len_err, 0);
      check("t4_no_flit", out_vld, 0);
      check("t4_idle", pkt_rdy, 1);
      repeat (2) @(negedge clk);
      check("t4_none", mon_q.size() - base, 0);
      send_req(2'd0, 2'd2, 4'd1);
      send_word(8'h3C);
      repeat (2) @(negedge clk);
      e = '{{2'b01, 8'h20}, {2'b11, 8'h3C}};
      chk_seq("t4", base, e);

      // Asynchronous reset mid-packet.
      @(negedge clk);
      send_req(2'd1, 2'd2, 4'd4);
      send_word(8'hB1);
      #1;
      check("t5_body", out_data, {2'b10, 8'hB1});
      #2;
      c0     = cyc_cnt;
      rst_ni = 1'b0;
      #1;
      check("t5_vld_drop", out_vld, 0);
      check("t5_data_clr", out_data, 0);
      check("t5_no_edge", cyc_cnt - c0, 0);
      check("t5_pkt_rdy", pkt_rdy, 0);
      check("t5_data_rdy", data_rdy, 0);
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      base = mon_q.size();
      send_req(2'd3, 2'd3, 4'd1);
      #1 check("t5_new_head", out_data, {2'b01, 8'hF0});
      @(negedge clk);
      send_word(8'h01);
      repeat (2) @(negedge clk);
      e = '{{2'b01, 8'hF0}, {2'b11, 8'h01}};
      chk_seq("t5", base, e);

      // Random ready/valid over 1000 packets against a scoreboard.
      for (int i = 0; i < 1000; i++) begin
         req_t       rq;
         logic [7:0] w;
         rq.row = 2'($urandom_range(3));
         rq.col = 2'($urandom_range(3));
         rq.len = 4'($urandom_range(6, 1));
         rq_q.push_back(rq);
         rnd_exp.push_back({2'b01, rq.row, rq.col, 4'b0000});
         for (int j = 0; j < int'(rq.len); j++) begin
            w = 8'($urandom_range(255));
            wd_q.push_back(w);
            rnd_exp.push_back({(j == int'(rq.len) - 1) ? 2'b11 : 2'b10, w});
         end
      end
      @(negedge clk);
      base      = mon_q.size();
      feed_done = 1'b0;
      fork
         begin
            fork
               rnd_req_drv();
               rnd_data_drv();
            join
            feed_done = 1'b1;
         end
         begin
            while (!feed_done) begin
               @(negedge clk);
               out_rdy = ($urandom_range(3) != 0);
            end
         end
      join
      out_rdy = 1'b1;
      repeat (4) @(negedge clk);
      check("rnd_count", mon_q.size() - base, rnd_exp.size());
      for (int i = 0; i < rnd_exp.size() && base + i < mon_q.size() && n_bad < 20; i++) begin
         check("rnd_flit", mon_q[base+i].flit, rnd_exp[i]);
         check("rnd_sent", mon_q[base+i].sent, rnd_exp[i][9:8] == 2'b11);
      end
      check("stray_sent", stray_sent, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
